// File: rtl/rat_pkg.sv
// Shared types and helpers for the multi-wide rename alias table.
// Holds arch register type, zero-register index and a priority encoder.
package rat_pkg;

   localparam int ARCH_REGS = 32;

   typedef logic [4:0] arch_reg_t;

   localparam arch_reg_t ZERO_REG = 5'd0;

   // Index of the lowest set bit among v[n-1:0]; 0 when none is set.
   // Callers widen their vector to 64 bits; bits at or above n are ignored.
   function automatic int lowest_set(
      input logic [63:0] v,
      input int          n
   );
      int r;
      r = 0;
      for (int i = 63; i >= 0; i--) begin
         if (i < n && v[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/rat_mw_ckpt_if.sv
// Rename/commit lane bus between decode/retire and the alias table.
// master: decode+ROB side drives lanes; slave: alias table answers.
interface rat_mw_ckpt_if #(
   parameter int PHYS_REG_BITS = 7,
   parameter int RN_WIDTH      = 2,
   parameter int COMMIT_WIDTH  = 2
);

   logic [RN_WIDTH-1:0]               rn_valid;
   logic [RN_WIDTH*5-1:0]             rn_rs1;
   logic [RN_WIDTH*5-1:0]             rn_rs2;
   logic [RN_WIDTH*5-1:0]             rn_rd;
   logic [RN_WIDTH*PHYS_REG_BITS-1:0] rn_pd;
   logic [RN_WIDTH*PHYS_REG_BITS-1:0] phys_rs1;
   logic [RN_WIDTH*PHYS_REG_BITS-1:0] phys_rs2;
   logic [RN_WIDTH*PHYS_REG_BITS-1:0] old_pd;

   logic [COMMIT_WIDTH-1:0]               commit_valid;
   logic [COMMIT_WIDTH*5-1:0]             commit_rd;
   logic [COMMIT_WIDTH*PHYS_REG_BITS-1:0] commit_pd;

   modport master (
      output rn_valid, rn_rs1, rn_rs2,
      output rn_rd, rn_pd,
      output commit_valid, commit_rd, commit_pd,
      input  phys_rs1, phys_rs2, old_pd
   );

   modport slave (
      input  rn_valid, rn_rs1, rn_rs2,
      input  rn_rd, rn_pd,
      input  commit_valid, commit_rd, commit_pd,
      output phys_rs1, phys_rs2, old_pd
   );

endinterface

// File: rtl/rat_ckpt_alloc.sv
// Checkpoint slot bookkeeping: valid bits, lowest-free id, full flag.
// Ports: clk/rst, flush, restore_en, ckpt_req, ckpt_free_mask in;
// ckpt_id, ckpt_full, ckpt_alloc out (ckpt_count when
// RAT_CKPT_OCCUPANCY_EN is defined).
module rat_ckpt_alloc
   import rat_pkg::*;
#(
   parameter  int NUM_CKPT  = 4,
   localparam int CKPT_BITS =
      (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 restore_en,
   input  logic                 ckpt_req,
   input  logic [NUM_CKPT-1:0]  ckpt_free_mask,
   output logic [CKPT_BITS-1:0] ckpt_id,
   output logic                 ckpt_full,
   output logic                 ckpt_alloc
`ifdef RAT_CKPT_OCCUPANCY_EN
   ,
   output logic [CKPT_BITS:0]   ckpt_count
`endif
);

   logic [NUM_CKPT-1:0] valid_q;
   logic [NUM_CKPT-1:0] valid_nx;

   // Allocation looks only at registered valid bits, so a slot
   // released this cycle is not handed out until the next one.
   assign ckpt_full = &valid_q;
   assign ckpt_id   = CKPT_BITS'(
      lowest_set(64'(~valid_q), NUM_CKPT));

   assign ckpt_alloc = ckpt_req && !ckpt_full &&
                       !restore_en && !flush && !rst;

   always_comb begin
      valid_nx = valid_q & ~ckpt_free_mask;
      if (ckpt_alloc) valid_nx[ckpt_id] = 1'b1;
      if (flush)      valid_nx = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_nx;
   end

`ifdef RAT_CKPT_OCCUPANCY_EN
   always_ff @(posedge clk) begin
      if (rst) ckpt_count <= '0;
      else     ckpt_count <= (CKPT_BITS+1)'($countones(valid_nx));
   end
`else
   // Occupancy counter not built.
`endif

endmodule

// File: rtl/rat_mw_ckpt.sv
// Multi-wide register alias table with branch checkpoints.
// Ports: clk/rst, flush, rn (lane bus), ckpt_req/lane/id/full,
// restore_en/id, ckpt_free_mask; ckpt_count if RAT_CKPT_OCCUPANCY_EN.
module rat_mw_ckpt
   import rat_pkg::*;
#(
   parameter  int PHYS_REG_BITS = 7,
   parameter  int RN_WIDTH      = 2,
   parameter  int COMMIT_WIDTH  = 2,
   parameter  int NUM_CKPT      = 4,
   localparam int CKPT_BITS =
      (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
   localparam int LANE_BITS =
      (RN_WIDTH > 1) ? $clog2(RN_WIDTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   rat_mw_ckpt_if.slave         rn,
   input  logic                 ckpt_req,
   input  logic [LANE_BITS-1:0] ckpt_lane,
   output logic [CKPT_BITS-1:0] ckpt_id,
   output logic                 ckpt_full,
   input  logic                 restore_en,
   input  logic [CKPT_BITS-1:0] restore_id,
   input  logic [NUM_CKPT-1:0]  ckpt_free_mask
`ifdef RAT_CKPT_OCCUPANCY_EN
   ,
   output logic [CKPT_BITS:0]   ckpt_count
`endif
);

   localparam int P = PHYS_REG_BITS;

   typedef logic [P-1:0] preg_t;

   preg_t spec_q [ARCH_REGS];
   preg_t comm_q [ARCH_REGS];
   preg_t ckpt_q [NUM_CKPT][ARCH_REGS];

   preg_t spec_nx [ARCH_REGS];
   preg_t comm_nx [ARCH_REGS];
   preg_t snap    [ARCH_REGS];

   logic ckpt_alloc;

   rat_ckpt_alloc #(
      .NUM_CKPT (NUM_CKPT)
   ) u_alloc (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .restore_en     (restore_en),
      .ckpt_req       (ckpt_req),
      .ckpt_free_mask (ckpt_free_mask),
      .ckpt_id        (ckpt_id),
      .ckpt_full      (ckpt_full),
      .ckpt_alloc     (ckpt_alloc)
`ifdef RAT_CKPT_OCCUPANCY_EN
      ,
      .ckpt_count     (ckpt_count)
`endif
   );

   // Lookups: older valid lanes of the same group override the map;
   // iterating oldest-first lets the youngest matching lane win.
   always_comb begin
      arch_reg_t s1, s2, d, rk;
      preg_t     p1, p2, po, pk;
      rn.phys_rs1 = '0;
      rn.phys_rs2 = '0;
      rn.old_pd   = '0;
      for (int j = 0; j < RN_WIDTH; j++) begin
         s1 = rn.rn_rs1[j*5 +: 5];
         s2 = rn.rn_rs2[j*5 +: 5];
         d  = rn.rn_rd[j*5 +: 5];
         p1 = spec_q[s1];
         p2 = spec_q[s2];
         po = spec_q[d];
         for (int k = 0; k < RN_WIDTH; k++) begin
            rk = rn.rn_rd[k*5 +: 5];
            pk = rn.rn_pd[k*P +: P];
            if (k < j && rn.rn_valid[k]) begin
               if (rk == s1) p1 = pk;
               if (rk == s2) p2 = pk;
               if (rk == d)  po = pk;
            end
         end
         if (s1 == ZERO_REG) p1 = '0;
         if (s2 == ZERO_REG) p2 = '0;
         if (d  == ZERO_REG) po = '0;
         rn.phys_rs1[j*P +: P] = p1;
         rn.phys_rs2[j*P +: P] = p2;
         rn.old_pd[j*P +: P]   = po;
      end
   end

   // Group write and partial-group snapshot; later lanes win.
   always_comb begin
      arch_reg_t rk;
      spec_nx = spec_q;
      snap    = spec_q;
      for (int k = 0; k < RN_WIDTH; k++) begin
         rk = rn.rn_rd[k*5 +: 5];
         if (rn.rn_valid[k] && rk != ZERO_REG) begin
            spec_nx[rk] = rn.rn_pd[k*P +: P];
            if (k <= int'(ckpt_lane))
               snap[rk] = rn.rn_pd[k*P +: P];
         end
      end
   end

   always_comb begin
      arch_reg_t rc;
      comm_nx = comm_q;
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
         rc = rn.commit_rd[c*5 +: 5];
         if (rn.commit_valid[c] && rc != ZERO_REG)
            comm_nx[rc] = rn.commit_pd[c*P +: P];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            spec_q[i] <= preg_t'(i);
            comm_q[i] <= preg_t'(i);
         end
      end else begin
         comm_q <= comm_nx;
         // Flush sees this cycle's commits so no retire is lost.
         if (flush)           spec_q <= comm_nx;
         else if (restore_en) spec_q <= ckpt_q[restore_id];
         else                 spec_q <= spec_nx;
      end
   end

   // Snapshot storage carries no reset; an invalid slot is never read.
   always_ff @(posedge clk) begin
      if (ckpt_alloc) ckpt_q[ckpt_id] <= snap;
   end

endmodule
